// File: rtl/pwm_duty_meter.sv
`default_nettype none
// ============================================================================
// Module   : pwm_duty_meter
// Purpose  : Measures a free-running PWM / pulse-density stream over fixed
//            windows of 2^WINDOW_LOG2 clk cycles. It reports the high-cycle
//            count (duty), the rising-edge count (edges) and a one-cycle
//            strobe per window. It also flags an input that has stayed
//            constant (no rising edges) for STUCK_WINDOWS consecutive windows.
// Ports    : clk        - single clock, rising edge
//            reset      - synchronous active-high reset
//            en         - measurement enable (synchronous)
//            pwm_in     - asynchronous input stream
//            duty       - high cycles of last complete window, saturated
//            edges      - rising edges of last complete window
//            duty_valid - one-cycle strobe: duty/edges just updated
//            stuck_high - input constant 1 for STUCK_WINDOWS windows
//            stuck_low  - input constant 0 for STUCK_WINDOWS windows
// Revision : 1.0 - initial release
// ============================================================================
module pwm_duty_meter #(
  parameter int WINDOW_LOG2   = 4,
  parameter int STUCK_WINDOWS = 4   // must be >= 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   pwm_in,
  output logic [WINDOW_LOG2-1:0] duty,
  output logic [WINDOW_LOG2-1:0] edges,
  output logic                   duty_valid,
  output logic                   stuck_high,
  output logic                   stuck_low
);

  localparam int STUCK_W = $clog2(STUCK_WINDOWS + 1);

  localparam logic [WINDOW_LOG2-1:0] WIN_LAST  = '1;
  localparam logic [STUCK_W-1:0]     STUCK_MAX = STUCK_W'(STUCK_WINDOWS);
  localparam logic [STUCK_W-1:0]     STUCK_ONE = STUCK_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRIME   = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t                 state;
  logic                   prime_cnt;
  logic                   sync1;
  logic                   s;
  logic                   s_prev;
  logic [WINDOW_LOG2-1:0] win_cnt;
  logic [WINDOW_LOG2:0]   high_cnt;   // one extra bit: an all-high window reaches 2^WINDOW_LOG2
  logic [WINDOW_LOG2-1:0] edge_cnt;   // at most 2^(WINDOW_LOG2-1) rises fit in a window
  logic [STUCK_W-1:0]     stuck_cnt;

  // --------------------------------------------------------------------------
  // Input synchronizer. It runs regardless of state so that s_prev always
  // holds the previous cycle's sample. An edge on the first cycle of a window
  // (or right after PRIME) is then seen against a real prior value.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b0;
      s      <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      sync1  <= pwm_in;
      s      <= sync1;
      s_prev <= s;
    end
  end

  // --------------------------------------------------------------------------
  // Per-cycle accumulation including the current sample. At window end these
  // are the complete window totals.
  // --------------------------------------------------------------------------
  logic                   rise;
  logic [WINDOW_LOG2:0]   high_total;
  logic [WINDOW_LOG2-1:0] edge_total;
  logic [WINDOW_LOG2-1:0] duty_sat;
  logic [STUCK_W-1:0]     stuck_next;

  always_comb begin
    rise       = s & ~s_prev;
    high_total = high_cnt + {{WINDOW_LOG2{1'b0}}, s};
    edge_total = edge_cnt + {{(WINDOW_LOG2-1){1'b0}}, rise};
    // An all-high window would need one more bit; clamp to the output range.
    if (high_total > {1'b0, WIN_LAST}) begin
      duty_sat = WIN_LAST;
    end else begin
      duty_sat = high_total[WINDOW_LOG2-1:0];
    end
    if (stuck_cnt == STUCK_MAX) begin
      stuck_next = STUCK_MAX;
    end else begin
      stuck_next = stuck_cnt + STUCK_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      prime_cnt  <= 1'b0;
      win_cnt    <= '0;
      high_cnt   <= '0;
      edge_cnt   <= '0;
      stuck_cnt  <= '0;
      duty       <= '0;
      edges      <= '0;
      duty_valid <= 1'b0;
      stuck_high <= 1'b0;
      stuck_low  <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      case (state)
        IDLE: begin
          prime_cnt <= 1'b0;
          win_cnt   <= '0;
          high_cnt  <= '0;
          edge_cnt  <= '0;
          if (en) begin
            state <= PRIME;
          end
        end

        PRIME: begin
          if (!en) begin
            state     <= IDLE;
            prime_cnt <= 1'b0;
            stuck_cnt <= '0;
          end else if (prime_cnt) begin
            // Second PRIME cycle: the synchronizer now holds post-enable data.
            state     <= MEASURE;
            prime_cnt <= 1'b0;
            win_cnt   <= '0;
            high_cnt  <= '0;
            edge_cnt  <= '0;
          end else begin
            prime_cnt <= 1'b1;
          end
        end

        MEASURE: begin
          if (!en) begin
            // Abandon the partial window; published results and flags hold.
            state     <= IDLE;
            win_cnt   <= '0;
            high_cnt  <= '0;
            edge_cnt  <= '0;
            stuck_cnt <= '0;
          end else if (win_cnt == WIN_LAST) begin
            duty       <= duty_sat;
            edges      <= edge_total;
            duty_valid <= 1'b1;
            // Next window starts on this same edge.
            win_cnt    <= '0;
            high_cnt   <= '0;
            edge_cnt   <= '0;
            if (edge_total == '0) begin
              stuck_cnt <= stuck_next;
              if (stuck_next == STUCK_MAX) begin
                // Level at window end decides the flag, so exactly one is set.
                stuck_high <= s;
                stuck_low  <= ~s;
              end
            end else begin
              stuck_cnt  <= '0;
              stuck_high <= 1'b0;
              stuck_low  <= 1'b0;
            end
          end else begin
            win_cnt  <= win_cnt + {{(WINDOW_LOG2-1){1'b0}}, 1'b1};
            high_cnt <= high_total;
            edge_cnt <= edge_total;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pwm_duty_meter
// Purpose  : Self-checking bench for pwm_duty_meter with a window-level
//            reference model computed from the recorded input history.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_meter;

  localparam int W   = 4;
  localparam int SW  = 4;
  localparam int WIN = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         pwm_in;
  logic [W-1:0] duty;
  logic [W-1:0] edges;
  logic         duty_valid;
  logic         stuck_high;
  logic         stuck_low;

  int tests = 0;
  int fails = 0;

  pwm_duty_meter #(.WINDOW_LOG2(W), .STUCK_WINDOWS(SW)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .pwm_in     (pwm_in),
    .duty       (duty),
    .edges      (edges),
    .duty_valid (duty_valid),
    .stuck_high (stuck_high),
    .stuck_low  (stuck_low)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model. p[k] is pwm_in as sampled at edge k. Two synchronizer
  // flops mean the sample measured at edge k is p[k-2], its predecessor
  // p[k-3]. run counts consecutive edges with en=1; the first run edge
  // enters PRIME, two PRIME edges follow, and every 16th edge after that
  // closes a window (run = 19, 35, ...).
  // --------------------------------------------------------------------------
  bit p [0:65535];
  int cyc = 0;
  int run = 0;
  bit m_valid = 1'b0;
  int m_duty = 0;
  int m_edges = 0;
  int m_stuck = 0;
  bit m_sh = 1'b0;
  bit m_sl = 1'b0;

  always @(posedge clk) begin : model
    int sum;
    int rises;
    bit cur;
    bit prv;
    p[cyc] = pwm_in;
    m_valid = 1'b0;
    if (reset) begin
      run = 0; m_duty = 0; m_edges = 0; m_stuck = 0; m_sh = 1'b0; m_sl = 1'b0;
    end else if (!en) begin
      run = 0; m_stuck = 0;
    end else begin
      run++;
      if (run >= WIN + 3 && ((run - 3) % WIN) == 0) begin
        sum = 0; rises = 0;
        for (int j = 0; j < WIN; j++) begin
          cur = p[cyc - 2 - j];
          prv = p[cyc - 3 - j];
          if (cur) sum++;
          if (cur && !prv) rises++;
        end
        m_duty  = (sum > WIN - 1) ? WIN - 1 : sum;
        m_edges = rises;
        m_valid = 1'b1;
        if (rises == 0) begin
          if (m_stuck < SW) m_stuck++;
          if (m_stuck == SW) begin
            m_sh = p[cyc - 2];
            m_sl = !p[cyc - 2];
          end
        end else begin
          m_stuck = 0; m_sh = 1'b0; m_sl = 1'b0;
        end
      end
    end
    cyc++;
  end

  logic [2*W+2:0] got;
  logic [2*W+2:0] want;
  assign got  = {duty_valid, duty, edges, stuck_high, stuck_low};
  assign want = {m_valid, m_duty[W-1:0], m_edges[W-1:0], m_sh, m_sl};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    repeat (n) step();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1; en = 1'b1; pwm_in = 1'b1;
    step(); step();
    tests++;
    if (got !== '0) begin
      fails++;
      $display("FAIL reset_outputs got=%h required=0", got);
    end
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL reset_model got=%h required=%h", got, want);
    end
    reset = 1'b0; en = 1'b0; pwm_in = 1'b0;
    step();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_delta_sigma();
    logic [3:0] acc;
    logic [4:0] sum5;
    int first;
    int nv;
    idle(3);
    acc = 4'd0; first = 0; nv = 0;
    sum5 = {1'b0, acc} + 5'd5; acc = sum5[3:0]; pwm_in = sum5[4];
    en = 1'b1;
    for (int i = 1; i <= 19 + 4 * WIN; i++) begin
      step();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL ds_model i=%0d got=%h required=%h", i, got, want);
      end
      if (duty_valid) begin
        nv++;
        if (first == 0) first = i;
        tests++;
        if (duty !== 4'd5 || edges !== 4'd5) begin
          fails++;
          $display("FAIL ds_level duty=%0d edges=%0d required 5/5", duty, edges);
        end
      end
      sum5 = {1'b0, acc} + 5'd5; acc = sum5[3:0]; pwm_in = sum5[4];
    end
    tests++;
    if (first != 19 || nv != 5) begin
      fails++;
      $display("FAIL ds_latency first=%0d windows=%0d required 19/5", first, nv);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_alternating();
    int nv;
    idle(3);
    nv = 0;
    en = 1'b1; pwm_in = 1'b1;
    for (int i = 1; i <= 19 + 3 * WIN; i++) begin
      step();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL alt_model i=%0d got=%h required=%h", i, got, want);
      end
      if (duty_valid) begin
        nv++;
        tests++;
        if (duty !== 4'd8 || edges !== 4'd8 || stuck_high || stuck_low) begin
          fails++;
          $display("FAIL alt_values duty=%0d edges=%0d sh=%b sl=%b required 8/8/0/0",
                   duty, edges, stuck_high, stuck_low);
        end
      end
      pwm_in = ~pwm_in;
    end
    tests++;
    if (nv != 4) begin
      fails++;
      $display("FAIL alt_windows got=%0d required=4", nv);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_held_high();
    int nv;
    pwm_in = 1'b1;
    idle(4);
    nv = 0;
    en = 1'b1;
    for (int i = 1; i <= 19 + 5 * WIN && nv < 5; i++) begin
      step();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL high_model i=%0d got=%h required=%h", i, got, want);
      end
      if (duty_valid) begin
        nv++;
        tests++;
        if (nv <= 4 && (duty !== 4'd15 || edges !== 4'd0 ||
                        stuck_high !== (nv >= 4) || stuck_low !== 1'b0)) begin
          fails++;
          $display("FAIL high_window%0d duty=%0d edges=%0d sh=%b sl=%b", nv, duty,
                   edges, stuck_high, stuck_low);
        end
        if (nv == 5 && (stuck_high !== 1'b0 || stuck_low !== 1'b0)) begin
          fails++;
          $display("FAIL high_clear sh=%b sl=%b required 0/0", stuck_high, stuck_low);
        end
      end
      // After the fourth window, a pulse train must clear the flag.
      pwm_in = (nv >= 4) ? ~pwm_in : 1'b1;
    end
    tests++;
    if (nv != 5) begin
      fails++;
      $display("FAIL high_windows got=%0d required=5", nv);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_held_low_then_reset();
    int nv;
    int first;
    pwm_in = 1'b0;
    idle(4);
    nv = 0;
    en = 1'b1;
    for (int i = 1; i <= 19 + 4 * WIN && nv < 4; i++) begin
      step();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL low_model i=%0d got=%h required=%h", i, got, want);
      end
      if (duty_valid) begin
        nv++;
        tests++;
        if (duty !== 4'd0 || edges !== 4'd0 || stuck_low !== (nv >= 4) || stuck_high !== 1'b0) begin
          fails++;
          $display("FAIL low_window%0d duty=%0d edges=%0d sh=%b sl=%b", nv, duty,
                   edges, stuck_high, stuck_low);
        end
      end
    end
    // Mid-window reset with stuck_low set; en stays high throughout.
    repeat (5) step();
    pwm_in = 1'b1;
    reset = 1'b1;
    step();
    tests++;
    if (got !== '0) begin
      fails++;
      $display("FAIL midreset_outputs got=%h required=0", got);
    end
    reset = 1'b0;
    first = 0;
    for (int i = 1; i <= 40 && first == 0; i++) begin
      step();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL midreset_model i=%0d got=%h required=%h", i, got, want);
      end
      if (duty_valid) first = i;
      pwm_in = 1'($urandom_range(0, 1));
    end
    tests++;
    if (first != 19) begin
      fails++;
      $display("FAIL midreset_restart first=%0d required=19", first);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_en_drop();
    int first;
    logic [W-1:0] hd;
    logic [W-1:0] he;
    idle(3);
    en = 1'b1; pwm_in = 1'($urandom_range(0, 1));
    first = 0;
    for (int i = 1; i <= 40 && first == 0; i++) begin
      step();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL drop_model i=%0d got=%h required=%h", i, got, want);
      end
      if (duty_valid) first = i;
      pwm_in = 1'($urandom_range(0, 1));
    end
    hd = m_duty[W-1:0];
    he = m_edges[W-1:0];
    repeat (9) begin
      step();
      pwm_in = 1'($urandom_range(0, 1));
    end
    en = 1'b0;
    repeat (3) begin
      step();
      tests++;
      if (duty_valid !== 1'b0 || duty !== hd || edges !== he) begin
        fails++;
        $display("FAIL drop_hold valid=%b duty=%0d edges=%0d required 0/%0d/%0d",
                 duty_valid, duty, edges, hd, he);
      end
      pwm_in = 1'($urandom_range(0, 1));
    end
    en = 1'b1;
    first = 0;
    for (int i = 1; i <= 40 && first == 0; i++) begin
      step();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL drop_resume i=%0d got=%h required=%h", i, got, want);
      end
      if (duty_valid) first = i;
      pwm_in = 1'($urandom_range(0, 1));
    end
    tests++;
    if (first != 19) begin
      fails++;
      $display("FAIL drop_latency first=%0d required=19", first);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_random();
    int density;
    int hold;
    density = 50; hold = 0;
    en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (i % 64 == 0) density = $urandom_range(0, 100);
      if (hold > 0) begin
        hold--;
        en = (hold == 0);
      end else if ($urandom_range(0, 199) == 0) begin
        hold = $urandom_range(1, 4);
        en = 1'b0;
      end
      pwm_in = ($urandom_range(0, 99) < density);
      step();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL random_model i=%0d got=%h required=%h", i, got, want);
      end
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; pwm_in = 1'b0;
    test_reset();
    test_delta_sigma();
    test_alternating();
    test_held_high();
    test_held_low_then_reset();
    test_en_drop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
